spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 116 +++++++++++
 tb/tb_spi_master.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master, mode 0, with a power-of-two SCK divider and a single-word shift register.
// Optional build macro SPI_MASTER_LSB_FIRST_EN switches transmit/receive to LSB first.
module spi_master #(
  parameter int CLK_DIV       = 2,
  parameter int DATA_WIDTH    = 8,
  parameter int BIT_CNT_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  miso,
  output logic                  mosi,
  output logic                  sck,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  new_data
);

  localparam int CNT_W = (BIT_CNT_WIDTH > $clog2(DATA_WIDTH)) ? BIT_CNT_WIDTH
                                                              : $clog2(DATA_WIDTH);
  localparam logic [CLK_DIV-1:0] DIV_RISE = CLK_DIV'((1 << (CLK_DIV - 1)) - 1);
  localparam logic [CLK_DIV-1:0] DIV_FALL = '1;
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE,
    TRANSFER
  } state_t;

  state_t                  state_q, state_d;
  logic [CLK_DIV-1:0]      div_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH-1:0]   sr_q;
  logic [DATA_WIDTH-1:0]   sr_shifted;
  logic                    tx_bit;
  logic                    first_bit;
  logic                    load;
  logic                    rise;
  logic                    fall;
  logic                    done;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign sr_shifted = {miso, sr_q[DATA_WIDTH-1:1]};
  assign tx_bit     = sr_q[0];
  assign first_bit  = data_in[0];
`else
  assign sr_shifted = {sr_q[DATA_WIDTH-2:0], miso};
  assign tx_bit     = sr_q[DATA_WIDTH-1];
  assign first_bit  = data_in[DATA_WIDTH-1];
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    rise    = 1'b0;
    fall    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = TRANSFER;
        end
      end
      TRANSFER: begin
        rise = (div_q == DIV_RISE);
        fall = (div_q == DIV_FALL);
        if (fall && (cnt_q == LAST_BIT)) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The divider wraps to zero on the final falling edge, so its MSB doubles as a
  // registered SCK that is guaranteed low whenever the FSM is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      cnt_q    <= '0;
      sr_q     <= '0;
      mosi     <= 1'b0;
      data_out <= '0;
      new_data <= 1'b0;
    end else begin
      state_q  <= state_d;
      new_data <= done;
      if (load) begin
        sr_q  <= data_in;
        mosi  <= first_bit;
        div_q <= '0;
        cnt_q <= '0;
      end else if (state_q == TRANSFER) begin
        div_q <= div_q + 1'b1;
        if (rise) begin
          sr_q <= sr_shifted;
        end
        if (fall) begin
          mosi  <= tx_bit;
          cnt_q <= done ? '0 : cnt_q + 1'b1;
        end
        if (done) begin
          data_out <= sr_q;
        end
      end
    end
  end

  assign sck  = div_q[CLK_DIV-1];
  assign busy = (state_q == TRANSFER);

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: a wide CLK_DIV=2 instance and a narrow CLK_DIV=1 instance,
// each compared cycle by cycle against a timing/bit-order model derived from transfer length.
module tb_spi_master;

  localparam int CD  = 2;
  localparam int DW  = 36;
  localparam int P   = 1 << CD;
  localparam int N   = DW * P;
  localparam int CD8 = 1;
  localparam int DW8 = 8;
  localparam int P8  = 1 << CD8;
  localparam int N8  = DW8 * P8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, loop_en, miso_drv, miso;
  logic [DW-1:0] data_in, data_out;
  logic          mosi, sck, busy, new_data;
  logic          start8, loop8, miso8_drv, miso8;
  logic [DW8-1:0] data_in8, data_out8;
  logic          mosi8, sck8, busy8, new_data8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign miso  = loop_en ? mosi  : miso_drv;
  assign miso8 = loop8   ? mosi8 : miso8_drv;

  spi_master #(.CLK_DIV(CD), .DATA_WIDTH(DW), .BIT_CNT_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .miso(miso),
    .mosi(mosi), .sck(sck), .busy(busy), .data_out(data_out), .new_data(new_data)
  );

  spi_master #(.CLK_DIV(CD8), .DATA_WIDTH(DW8), .BIT_CNT_WIDTH(3)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .data_in(data_in8), .miso(miso8),
    .mosi(mosi8), .sck(sck8), .busy(busy8), .data_out(data_out8), .new_data(new_data8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Index of the data bit carried in bit period b (period 0 is the first on the wire).
  function automatic int bitpos(input int b, input int w);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return b;
`else
    return w - 1 - b;
`endif
  endfunction

  // Busy cycle k (1-based): SCK low for the first half of each period, high for the second.
  function automatic logic exp_sck(input int k, input int per);
    return ((k - 1) % per) >= (per / 2);
  endfunction

  task automatic xfer36(input logic [DW-1:0] d, input bit loop, input logic [DW-1:0] s,
                        input int restart_at, input int abort_at, input bit hold);
    logic [DW-1:0] exp_out;
    int b;
    int cnt;
    int pulses;
    exp_out = loop ? d : s;
    @(negedge clk);
    data_in  = d;
    loop_en  = loop;
    start    = 1'b1;
    miso_drv = s[bitpos(0, DW)];
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      if (k == restart_at) begin
        start   = 1'b1;
        data_in = ~d;
      end else if (!hold) begin
        start = 1'b0;
      end
      b = (k - 1) / P;
      miso_drv = s[bitpos(b, DW)];
      check("busy36", busy, 1'b1);
      check("sck36", sck, exp_sck(k, P));
      check("mosi36", mosi, d[bitpos(b, DW)]);
      check("nd_mid36", new_data, 1'b0);
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_sck", sck, 1'b0);
        check("abort_mosi", mosi, 1'b0);
        check("abort_dout", data_out, '0);
        check("abort_nd", new_data, 1'b0);
        pulses = 0;
        for (int j = 0; j < N + 4; j++) begin
          @(negedge clk);
          if (new_data || busy) pulses++;
        end
        check("abort_quiet", pulses, 0);
        return;
      end
    end
    @(negedge clk);
    check("end_busy36", busy, 1'b0);
    check("end_nd36", new_data, 1'b1);
    check("end_sck36", sck, 1'b0);
    check("dout36", data_out, exp_out);
    if (hold) begin
      @(negedge clk);
      check("retrig_busy", busy, 1'b1);
      start = 1'b0;
      cnt = 1;
      while (cnt < 2 * N) begin
        @(negedge clk);
        if (!busy) break;
        cnt++;
      end
      check("retrig_len", cnt, N);
      check("retrig_nd", new_data, 1'b1);
      check("retrig_dout", data_out, exp_out);
    end
    @(negedge clk);
    check("nd_once36", new_data, 1'b0);
    check("idle_sck36", sck, 1'b0);
  endtask

  task automatic xfer8(input logic [DW8-1:0] d, input bit loop, input logic mval);
    logic [DW8-1:0] exp_out;
    int b;
    exp_out = loop ? d : {DW8{mval}};
    @(negedge clk);
    data_in8  = d;
    loop8     = loop;
    miso8_drv = mval;
    start8    = 1'b1;
    for (int k = 1; k <= N8; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      b = (k - 1) / P8;
      check("busy8", busy8, 1'b1);
      check("sck8", sck8, exp_sck(k, P8));
      check("mosi8", mosi8, d[bitpos(b, DW8)]);
      check("nd_mid8", new_data8, 1'b0);
    end
    @(negedge clk);
    check("end_busy8", busy8, 1'b0);
    check("end_nd8", new_data8, 1'b1);
    check("dout8", data_out8, exp_out);
    @(negedge clk);
    check("nd_once8", new_data8, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] r;
    rst = 1'b1;
    start = 1'b0; loop_en = 1'b1; miso_drv = 1'b0; data_in = '0;
    start8 = 1'b0; loop8 = 1'b1; miso8_drv = 1'b0; data_in8 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_sck", sck, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_dout", data_out, '0);
    check("rst_nd", new_data, 1'b0);
    check("rst_busy8", busy8, 1'b0);
    check("rst_dout8", data_out8, '0);

    xfer36(36'h9_A5A5_3C3C, 1'b1, '0, 0, 0, 1'b0);
    r = {$urandom, $urandom};
    xfer36(r, 1'b0, 36'hF_0000_1234, 0, 0, 1'b0);
    r = {$urandom, $urandom};
    xfer36(r, 1'b1, '0, 50, 0, 1'b0);
    r = {$urandom, $urandom};
    xfer36(r, 1'b1, '0, 0, 70, 1'b0);
    r = {$urandom, $urandom};
    xfer36(r, 1'b1, '0, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] s;
      r = {$urandom, $urandom};
      s = {$urandom, $urandom};
      xfer36(r, 1'($urandom_range(0, 1)), s, 0, 0, 1'b0);
    end

    xfer8(8'hC3, 1'b0, 1'b1);
    xfer8(8'h01, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      xfer8(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
